// File: rtl/seq_cla_adder_if.sv
// Operand/result bundle for seq_cla_adder.
// Optional sub line exists only with SEQ_CLA_SUB_EN.
interface seq_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
`ifdef SEQ_CLA_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
`ifdef SEQ_CLA_SUB_EN
    output sub,
`endif
    output start, in1, in2, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
`ifdef SEQ_CLA_SUB_EN
    input  sub,
`endif
    input  start, in1, in2, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/seq_cla_adder.sv
// Nibble-serial WIDTH-bit adder around one CLA_4bit slice.
// Ports: clk, rst (sync, high), bus (slave): start/in1/in2/c_in[/sub] in,
// busy/done/sum/c_out out. Macro SEQ_CLA_SUB_EN adds subtract mode.
module CLA_4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic [4:1] carry
);
  logic [3:0] g;
  logic [3:0] p;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  assign carry[1] = g[0] | (p[0] & c_in);
  assign carry[2] = g[1] | (p[1] & g[0])
                  | (p[1] & p[0] & c_in);
  assign carry[3] = g[2] | (p[2] & g[1])
                  | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c_in);
  assign carry[4] = g[3] | (p[3] & g[2])
                  | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum = p ^ {carry[3:1], c_in};
endmodule

module seq_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  seq_cla_adder_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  wire        c4;
  wire [3:1]  unused_carry;

  assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
  assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

  CLA_4bit u_cla (
    .in1   (nib_a),
    .in2   (nib_b),
    .c_in  (cy_q),
    .sum   (nib_s),
    .carry ({c4, unused_carry})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.in1;
`ifdef SEQ_CLA_SUB_EN
          // Two's complement: invert B, force carry-in.
          b_d  = bus.sub ? ~bus.in2 : bus.in2;
          cy_d = bus.sub ? 1'b1 : bus.c_in;
`else
          b_d  = bus.in2;
          cy_d = bus.c_in;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = nib_s;
        end
        cy_d  = c4;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = c4;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
endmodule

// File: doc/seq_cla_adder.md
# seq_cla_adder

Multi-cycle WIDTH-bit adder that sits directly upstream of the `CLA_4bit` slice and drives it one nibble per clock. It latches two operands on a start pulse and presents nibble *i* of each operand plus the registered carry to a single `CLA_4bit` instance. It collects the slice's `sum` and `carry[4]` back into a result register and flags completion with a one-cycle `done` pulse. It trades latency for area against a flat WIDTH-bit carry-lookahead adder.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `in1` input WIDTH: operand A; latched when start is accepted.
- `in2` input WIDTH: operand B; latched when start is accepted.
- `c_in` input 1: carry into nibble 0; latched when start is accepted.
- `sub` input 1: present only when `SEQ_CLA_SUB_EN` is defined; latched when start is accepted.
- `busy` output 1: high while nibbles are being processed.
- `done` output 1: one-cycle pulse when the result is valid.
- `sum` output WIDTH: result register.
- `c_out` output 1: carry out of the top nibble.

## Operation
- Exactly one `CLA_4bit` instance, with ports `in1`, `in2`, `c_in`, `sum` and `carry[4:1]`. It is fed from the operand registers at nibble index `cnt`, and its carry input comes from the internal carry register `cy`.
- FSM states: IDLE, RUN, DONE.
- IDLE, with `start`=1:
  - Latch `in1` into A, `in2` into B, and `c_in` into `cy`.
  - Set `cnt`=0 and go to RUN.
  - `start`=0 keeps the FSM in IDLE.
- RUN, each clock:
  - Write `sum[4*cnt+3:4*cnt]` from the slice `sum`.
  - Set `cy` to slice `carry[4]`.
  - Increment `cnt`.
  - On the edge where `cnt`==N-1, also load `c_out` from slice `carry[4]` and go to DONE.
- DONE lasts one cycle with `done`=1, then the FSM returns to IDLE.
- `busy`=1 exactly in RUN.
- `start` in RUN or DONE is ignored. It is not queued.
- Operands are registered, so changes on `in1`, `in2`, `c_in` or `sub` after acceptance have no effect on the result in progress.
- `sum` and `c_out` contents during RUN are partial and must not be consumed.
  - From `done` onward they hold the final result until the next accepted start.
- Arithmetic: {`c_out`, `sum`} = A + B + `c_in`, modulo 2^(WIDTH+1). There is no overflow flag.
- `cnt` width is clog2(N), with a minimum of 1. For N=1, RUN lasts one cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `cnt`=0, `cy`=0.
- Latency, with start accepted at edge k:
  - RUN occupies edges k+1 through k+N.
  - `done` is high for the cycle between edge k+N and edge k+N+1.
  - For WIDTH=16, `done` follows the accepting edge by 4 cycles.
- Throughput: at most one operation per N+2 cycles. The earliest next start is accepted at edge k+N+2.
- `rst` during RUN or DONE:
  - Operation is aborted, no `done` is produced, and all outputs return to reset values on that edge.
  - `rst` has priority over `start` on the same edge.

## Configuration
- `SEQ_CLA_SUB_EN` defined:
  - The `sub` port exists.
  - With `sub`=1 at acceptance, B is latched as ~`in2` and `cy` as 1, ignoring `c_in`. Result = `in1` − `in2` mod 2^WIDTH.
  - `c_out`=1 means no borrow.
  - With `sub`=0, behaviour is identical to the undefined case.
- `SEQ_CLA_SUB_EN` undefined: no `sub` port and an add-only datapath.

## Test plan
All scenarios use WIDTH=16.
- Basic add: `in1`=0x1234, `in2`=0x4321, `c_in`=0, start → `busy` for 4 cycles, then `done` pulse with `sum`=0x5555, `c_out`=0.
- Full ripple: 0xFFFF + 0x0001, `c_in`=0 → `sum`=0x0000, `c_out`=1. Also 0xFFFF + 0xFFFF, `c_in`=1 → `sum`=0xFFFF, `c_out`=1.
- Carry-in: 0x0004 + 0x0004, `c_in`=1 → `sum`=0x0009, `c_out`=0. After `done`, `sum` stays 0x0009 for 10 idle cycles.
- Ignored start and operand change: during RUN, pulse `start` with `in1`=0xAAAA, `in2`=0x5555 → exactly one `done`, carrying the first operation's result. A subsequent start in IDLE yields 0xFFFF, `c_out`=0.
- Reset mid-run: assert `rst` at RUN cycle 2 → next cycle `busy`=0, `sum`=0, `c_out`=0, no `done`. A new start of 0x0001 + 0x0002 then gives 0x0003.
- With `SEQ_CLA_SUB_EN`:
  - `sub`=1, 0x0005 − 0x0007 → `sum`=0xFFFE, `c_out`=0.
  - `sub`=1, 0x0007 − 0x0005 → `sum`=0x0002, `c_out`=1.
